bitscan_encoder: RTL and testbench



---
 rtl/bitscan_encoder.sv | 132 +++++++++++++
 tb/tb_bitscan_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitscan_encoder.sv
// Multi-hot bit-scan encoder: captures a request vector and emits the index of each set bit,
// one per output handshake, in LSB-first or MSB-first order; an all-zero vector yields one flagged beat.
module bitscan_encoder #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IDX_W     = $clog2(WIDTH),
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic [IDX_W:0]   out_cnt
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    ZERO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Priority select: the last match in the loop wins, so scan direction sets the priority.
  function automatic logic [IDX_W-1:0] pick(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) idx = IDX_W'(i);
      end else begin
        if (v[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
      end
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  // Output registers are loaded from the next-state view so they track state and pending exactly.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    ready_d   = 1'b0;
    zero_d    = 1'b0;
    last_d    = 1'b0;
    idx_d     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          cnt_d     = popcount(in_vec);
          state_d   = (in_vec != '0) ? SCAN : ZERO;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_d = pending_q & ~(WIDTH'(1) << idx_q);
          if (last_q) state_d = IDLE;
        end
      end
      ZERO: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    zero_d  = (state_d == ZERO);
    idx_d   = pick(pending_d);
    last_d  = zero_d || ((state_d == SCAN) && single_bit(pending_d));
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_zero  = zero_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_bitscan_encoder.sv
// Bench for bitscan_encoder: LSB-first and MSB-first WIDTH=16 instances run in lockstep,
// plus a WIDTH=5 instance; outputs are compared against a queue-based bit-order model.
module tb_bitscan_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_ab, in_valid_c, out_ready;
  logic [15:0] in_vec;
  logic [4:0]  in_vec_c;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_zero;
  logic [3:0] a_out_idx;
  logic [4:0] a_out_cnt;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_zero;
  logic [3:0] b_out_idx;
  logic [4:0] b_out_cnt;
  logic       c_in_ready, c_out_valid, c_out_last, c_out_zero;
  logic [2:0] c_out_idx;
  logic [3:0] c_out_cnt;

  bitscan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid_ab), .in_ready(a_in_ready), .in_vec(in_vec),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_out_idx),
    .out_last(a_out_last), .out_zero(a_out_zero), .out_cnt(a_out_cnt));

  bitscan_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid_ab), .in_ready(b_in_ready), .in_vec(in_vec),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_out_idx),
    .out_last(b_out_last), .out_zero(b_out_zero), .out_cnt(b_out_cnt));

  bitscan_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) dut_w5 (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(c_in_ready), .in_vec(in_vec_c),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_idx(c_out_idx),
    .out_last(c_out_last), .out_zero(c_out_zero), .out_cnt(c_out_cnt));

  int n_checks = 0;
  int n_pass   = 0;
  int first_a, first_b, first_cnt, nbeats;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Model: expected beat order is just the list of set-bit positions, ascending or descending.
  task automatic run_burst(input bit use_c, input logic [15:0] vec, input int stall_pct, input bit poke);
    int qa[$];
    int qb[$];
    int w, cnt, guard;
    bit rdy, first;
    w = use_c ? 5 : 16;
    for (int i = 0; i < w; i++) if (vec[i]) qa.push_back(i);
    for (int i = w - 1; i >= 0; i--) if (vec[i]) qb.push_back(i);
    cnt = qa.size();
    if (cnt == 0) begin
      qa.push_back(0);
      qb.push_back(0);
    end
    guard = 0;
    while (!(use_c ? c_in_ready : a_in_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_capture", use_c ? int'(c_in_ready) : int'(a_in_ready), 1);
    out_ready = 1'b0;
    if (use_c) begin
      in_vec_c   = vec[4:0];
      in_valid_c = 1'b1;
    end else begin
      in_vec      = vec;
      in_valid_ab = 1'b1;
    end
    @(negedge clk);
    if (!poke) begin
      in_valid_ab = 1'b0;
      in_valid_c  = 1'b0;
    end
    first  = 1'b1;
    nbeats = 0;
    guard  = 0;
    while (qa.size() > 0 && guard < 400) begin
      if (use_c) begin
        check("c_valid", int'(c_out_valid), 1);
        check("c_in_ready_low", int'(c_in_ready), 0);
        check("c_idx", int'(c_out_idx), qa[0]);
        check("c_last", int'(c_out_last), int'(qa.size() == 1));
        check("c_zero", int'(c_out_zero), int'(cnt == 0));
        check("c_cnt", int'(c_out_cnt), cnt);
      end else begin
        check("a_valid", int'(a_out_valid), 1);
        check("a_in_ready_low", int'(a_in_ready), 0);
        check("a_idx", int'(a_out_idx), qa[0]);
        check("a_last", int'(a_out_last), int'(qa.size() == 1));
        check("a_zero", int'(a_out_zero), int'(cnt == 0));
        check("a_cnt", int'(a_out_cnt), cnt);
        check("b_valid", int'(b_out_valid), 1);
        check("b_idx", int'(b_out_idx), qb[0]);
        check("b_last", int'(b_out_last), int'(qb.size() == 1));
        check("b_zero", int'(b_out_zero), int'(cnt == 0));
        check("b_cnt", int'(b_out_cnt), cnt);
      end
      if (first) begin
        first_a   = use_c ? int'(c_out_idx) : int'(a_out_idx);
        first_b   = int'(b_out_idx);
        first_cnt = use_c ? int'(c_out_cnt) : int'(a_out_cnt);
        first     = 1'b0;
      end
      rdy       = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      if (poke) begin
        in_vec   = 16'($urandom);
        in_vec_c = 5'($urandom);
      end
      if (rdy) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        nbeats++;
        if (qa.size() == 0) begin
          in_valid_ab = 1'b0;
          in_valid_c  = 1'b0;
        end
      end
      @(negedge clk);
      guard++;
    end
    check("drain_done", qa.size(), 0);
    check("ready_after_burst", use_c ? int'(c_in_ready) : int'(a_in_ready), 1);
    check("valid_after_burst", use_c ? int'(c_out_valid) : int'(a_out_valid), 0);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] vec;
    int          cnt;
    int          lsb;
    int          msb;
    int          beats;
    int          stall;
  } vec_t;

  vec_t tbl[8];
  logic [15:0] rv;

  initial begin
    tbl[0] = '{16'h0400, 1, 10, 10, 1, 0};
    tbl[1] = '{16'h8421, 4, 0, 15, 4, 0};
    tbl[2] = '{16'h0000, 0, 0, 0, 1, 0};
    tbl[3] = '{16'hFFFF, 16, 0, 15, 16, 0};
    tbl[4] = '{16'h8000, 1, 15, 15, 1, 40};
    tbl[5] = '{16'h0001, 1, 0, 0, 1, 0};
    tbl[6] = '{16'h5A00, 4, 9, 14, 4, 25};
    tbl[7] = '{16'h0000, 0, 0, 0, 1, 50};

    rst         = 1'b1;
    in_valid_ab = 1'b0;
    in_valid_c  = 1'b0;
    out_ready   = 1'b0;
    in_vec      = '0;
    in_vec_c    = '0;
    #12;
    check("rst_valid", int'(a_out_valid), 0);
    check("rst_idx", int'(a_out_idx), 0);
    check("rst_last", int'(a_out_last), 0);
    check("rst_zero", int'(a_out_zero), 0);
    check("rst_cnt", int'(a_out_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(a_in_ready), 1);
    check("post_rst_ready_w5", int'(c_in_ready), 1);

    for (int k = 0; k < 8; k++) begin
      run_burst(1'b0, tbl[k].vec, tbl[k].stall, 1'b0);
      check("tbl_cnt", first_cnt, tbl[k].cnt);
      check("tbl_first_lsb", first_a, tbl[k].lsb);
      check("tbl_first_msb", first_b, tbl[k].msb);
      check("tbl_beats", nbeats, tbl[k].beats);
    end

    // Stall on the first beat of 16'h0003 while a new vector is offered mid-burst.
    in_vec      = 16'h0003;
    in_valid_ab = 1'b1;
    out_ready   = 1'b0;
    @(negedge clk);
    in_vec = 16'hF0F0;
    for (int s = 0; s < 3; s++) begin
      check("stall_valid", int'(a_out_valid), 1);
      check("stall_idx", int'(a_out_idx), 0);
      check("stall_last", int'(a_out_last), 0);
      check("stall_cnt", int'(a_out_cnt), 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("stall_beat0", int'(a_out_idx), 0);
    @(negedge clk);
    check("stall_beat1", int'(a_out_idx), 1);
    check("stall_beat1_last", int'(a_out_last), 1);
    check("stall_beat1_cnt", int'(a_out_cnt), 2);
    in_valid_ab = 1'b0;
    @(negedge clk);
    check("stall_ready_back", int'(a_in_ready), 1);
    check("stall_no_capture", int'(a_out_valid), 0);
    out_ready = 1'b0;
    @(negedge clk);
    check("stall_still_idle", int'(a_out_valid), 0);

    // Reset during the second beat of an all-ones burst.
    in_vec      = 16'hFFFF;
    in_valid_ab = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    in_valid_ab = 1'b0;
    check("ffff_beat0", int'(a_out_idx), 0);
    check("ffff_cnt", int'(a_out_cnt), 16);
    @(negedge clk);
    check("ffff_beat1", int'(a_out_idx), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid_a", int'(a_out_valid), 0);
    check("midrst_valid_b", int'(b_out_valid), 0);
    check("midrst_idx", int'(a_out_idx), 0);
    check("midrst_cnt", int'(a_out_cnt), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("midrst_idle_valid", int'(a_out_valid), 0);
    check("midrst_idle_ready", int'(a_in_ready), 1);

    // WIDTH=5 instance.
    run_burst(1'b1, 16'h0011, 0, 1'b0);
    check("w5_cnt", first_cnt, 2);
    check("w5_first", first_a, 0);
    check("w5_beats", nbeats, 2);
    run_burst(1'b1, 16'h001F, 0, 1'b0);
    check("w5_ones_cnt", first_cnt, 5);
    check("w5_ones_beats", nbeats, 5);

    for (int r = 0; r < 40; r++) begin
      rv = 16'($urandom) & 16'($urandom);
      run_burst(1'b0, rv, 30, 1'($urandom_range(1)));
    end
    for (int r = 0; r < 20; r++) begin
      rv = 16'($urandom_range(31));
      run_burst(1'b1, rv, 30, 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
